// File: rtl/rs232_mem_cmd_ctrl.sv
// Byte-stream command parser sitting between the RS232 receiver/transmitter and a
// 16K x 8 memory macro: 'W' hi lo data writes a byte and answers ACK, 'R' hi lo answers the byte read.
module rs232_mem_cmd_ctrl #(
    parameter logic [7:0] CMD_WR   = 8'h57,
    parameter logic [7:0] CMD_RD   = 8'h52,
    parameter logic [7:0] ACK_BYTE = 8'h06,
    parameter int         TO_W     = 16,
    parameter int         TIMEOUT  = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [13:0] mem_addr,
    output logic        mem_write,
    output logic [7:0]  mem_data_in,
    input  logic [7:0]  mem_data_out,
    output logic        busy,
    output logic        err
);

    // Handshake: a tx byte transfers at a clk edge where tx_valid & tx_ready are both high;
    // once tx_valid rises, tx_valid and tx_data hold unchanged until that transfer edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        AHI     = 3'd1,
        ALO     = 3'd2,
        DAT     = 3'd3,
        WR_DONE = 3'd4,
        RD_WAIT = 3'd5,
        RD_CAP  = 3'd6,
        TX      = 3'd7
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q;
    logic            op_wr_q;
    logic [5:0]      ahi_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [TO_W-1:0] to_cnt_d;
    logic            to_expire;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;
    logic [13:0]     mem_addr_q;
    logic            mem_write_q;
    logic [7:0]      mem_data_in_q;
    logic            busy_q;
    logic            err_q;

    // Inter-byte idle counter: only runs while waiting for the rest of a command,
    // and an arriving byte on the expiry cycle takes priority over the timeout.
    always_comb begin
        to_cnt_d  = '0;
        to_expire = 1'b0;
        if ((state_q == AHI || state_q == ALO || state_q == DAT) && !rx_valid) begin
            if (TIMEOUT != 0 && to_cnt_q == TO_LAST) begin
                to_expire = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            op_wr_q       <= 1'b0;
            ahi_q         <= '0;
            to_cnt_q      <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_write_q   <= 1'b0;
            mem_data_in_q <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            err_q    <= 1'b0;
            to_cnt_q <= to_cnt_d;
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                            op_wr_q <= (rx_data == CMD_WR);
                            state_q <= AHI;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                AHI: begin
                    if (rx_valid) begin
                        ahi_q   <= rx_data[5:0];
                        state_q <= ALO;
                    end else if (to_expire) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ALO: begin
                    if (rx_valid) begin
                        mem_addr_q <= {ahi_q, rx_data};
                        state_q    <= op_wr_q ? DAT : RD_WAIT;
                    end else if (to_expire) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                DAT: begin
                    if (rx_valid) begin
                        mem_data_in_q <= rx_data;
                        mem_write_q   <= 1'b1;
                        state_q       <= WR_DONE;
                    end else if (to_expire) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                WR_DONE: begin
                    mem_write_q <= 1'b0;
                    tx_data_q   <= ACK_BYTE;
                    tx_valid_q  <= 1'b1;
                    state_q     <= TX;
                    err_q       <= rx_valid;
                end
                RD_WAIT: begin
                    // The macro registers the read address at this edge; data is usable next cycle.
                    state_q <= RD_CAP;
                    err_q   <= rx_valid;
                end
                RD_CAP: begin
                    tx_data_q  <= mem_data_out;
                    tx_valid_q <= 1'b1;
                    state_q    <= TX;
                    err_q      <= rx_valid;
                end
                TX: begin
                    err_q <= rx_valid;
                    if (tx_valid_q && tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign mem_addr    = mem_addr_q;
    assign mem_write   = mem_write_q;
    assign mem_data_in = mem_data_in_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_rs232_mem_cmd_ctrl.sv
// Bench for rs232_mem_cmd_ctrl: directed command sequences plus random write/read traffic,
// checked against an array model of the memory and an expected tx byte queue.
module tb_rs232_mem_cmd_ctrl;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [13:0] mem_addr;
    logic        mem_write;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;
    int err_seen = 0;
    int wr_seen  = 0;
    int exp_err  = 0;
    int exp_wr   = 0;

    logic [7:0]  macro_mem [0:16383];
    logic [7:0]  ref_mem   [0:16383];
    logic [7:0]  exp_q[$];
    logic [13:0] pool [6] = '{14'h0000, 14'h3FFF, 14'h1234, 14'h0155, 14'h2AAA, 14'h1000};

    always #5 clk = ~clk;

    rs232_mem_cmd_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .mem_addr     (mem_addr),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .busy         (busy),
        .err          (err)
    );

    // Memory macro: registered read, output forced to 0 on a write cycle.
    always @(posedge clk) begin
        if (mem_write) begin
            macro_mem[mem_addr] <= mem_data_in;
            mem_data_out        <= 8'h00;
        end else begin
            mem_data_out <= macro_mem[mem_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are stable by the falling edge, so this sees exactly the handshakes of the next rising edge.
    always @(negedge clk) begin
        if (err) err_seen++;
        if (mem_write) wr_seen++;
        if (!rst && tx_valid && tx_ready) begin
            check_val("tx_unexp", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check_val("tx_byte", tx_data, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic tx_finish(input logic [7:0] exp_b, input int wait_n, input bit inject);
        tx_ready = 1'b0;
        for (int i = 0; i < wait_n; i++) begin
            if (inject && i == wait_n / 2) begin
                send_byte(8'h41);
                exp_err++;
                check_val("bp_err", err, 1'b1);
                check_val("bp_busy", busy, 1'b1);
            end else begin
                idle(1);
            end
            check_val("bp_valid", tx_valid, 1'b1);
            check_val("bp_data", tx_data, exp_b);
        end
        exp_q.push_back(exp_b);
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;
        check_val("tx_drop", tx_valid, 1'b0);
        check_val("tx_idle", busy, 1'b0);
    endtask

    task automatic do_write(input logic [13:0] addr, input logic [1:0] junk, input logic [7:0] data,
                            input int wait_n);
        send_byte(8'h57);
        check_val("wr_busy", busy, 1'b1);
        send_byte({junk, addr[13:8]});
        send_byte(addr[7:0]);
        send_byte(data);
        ref_mem[addr] = data;
        exp_wr++;
        check_val("wr_we", mem_write, 1'b1);
        check_val("wr_addr", mem_addr, addr);
        check_val("wr_data", mem_data_in, data);
        check_val("wr_txv0", tx_valid, 1'b0);
        idle(1);
        check_val("wr_pulse", mem_write, 1'b0);
        check_val("wr_txv", tx_valid, 1'b1);
        check_val("wr_ack", tx_data, 8'h06);
        tx_finish(8'h06, wait_n, 1'b0);
    endtask

    task automatic do_read(input logic [13:0] addr, input logic [1:0] junk, input int wait_n,
                           input bit inject);
        send_byte(8'h52);
        send_byte({junk, addr[13:8]});
        send_byte(addr[7:0]);
        check_val("rd_addr", mem_addr, addr);
        check_val("rd_we", mem_write, 1'b0);
        check_val("rd_lat0", tx_valid, 1'b0);
        idle(1);
        check_val("rd_lat1", tx_valid, 1'b0);
        idle(1);
        check_val("rd_lat2", tx_valid, 1'b1);
        check_val("rd_data", tx_data, ref_mem[addr]);
        tx_finish(ref_mem[addr], wait_n, inject);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_txv"}, tx_valid, 1'b0);
        check_val({tag, "_txd"}, tx_data, 8'h00);
        check_val({tag, "_we"}, mem_write, 1'b0);
        check_val({tag, "_addr"}, mem_addr, 14'h0000);
        check_val({tag, "_din"}, mem_data_in, 8'h00);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        logic [7:0]  b;
        logic [13:0] a;
        for (int i = 0; i < 16384; i++) begin
            macro_mem[i] = 8'h00;
            ref_mem[i]   = 8'h00;
        end
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        idle(3);
        check_all_zero("reset");
        rst = 1'b0;
        idle(1);

        // Write then readback, address masking, backpressure with a dropped byte.
        do_write(14'h1234, 2'b00, 8'hA5, 0);
        do_read(14'h1234, 2'b00, 0, 1'b0);
        do_read(14'h1234, 2'b11, 0, 1'b0);
        do_read(14'h3FFF, 2'b00, 1, 1'b0);
        do_write(14'h3FFF, 2'b10, 8'h5C, 2);
        do_read(14'h3FFF, 2'b01, 0, 1'b0);
        do_read(14'h1234, 2'b00, 10, 1'b1);

        // Timeout while waiting for the low address byte.
        send_byte(8'h57);
        send_byte(8'h12);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            idle(1);
            check_val("to_busy", busy, 1'b1);
            check_val("to_quiet", err, 1'b0);
        end
        idle(1);
        exp_err++;
        check_val("to_err", err, 1'b1);
        check_val("to_idle", busy, 1'b0);
        idle(1);
        check_val("to_pulse", err, 1'b0);

        // A byte arriving exactly on the expiry cycle is accepted, twice in one command.
        send_byte(8'h57);
        send_byte(8'h12);
        idle(TIMEOUT - 1);
        send_byte(8'h34);
        check_val("edge_err", err, 1'b0);
        check_val("edge_busy", busy, 1'b1);
        idle(TIMEOUT - 1);
        send_byte(8'h77);
        ref_mem[14'h1234] = 8'h77;
        exp_wr++;
        check_val("edge_we", mem_write, 1'b1);
        check_val("edge_addr", mem_addr, 14'h1234);
        check_val("edge_din", mem_data_in, 8'h77);
        idle(1);
        check_val("edge_ack", tx_data, 8'h06);
        tx_finish(8'h06, 0, 1'b0);

        // Timeout while waiting for data: no write may reach the macro.
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h10);
        idle(TIMEOUT - 1);
        check_val("to2_busy", busy, 1'b1);
        idle(1);
        exp_err++;
        check_val("to2_err", err, 1'b1);
        check_val("to2_busy0", busy, 1'b0);
        check_val("to2_we", mem_write, 1'b0);

        // Bad opcode in IDLE.
        send_byte(8'h00);
        exp_err++;
        check_val("badop_err", err, 1'b1);
        check_val("badop_busy", busy, 1'b0);
        idle(1);
        check_val("badop_pulse", err, 1'b0);

        // Reset on the edge that would accept the data byte.
        send_byte(8'h57);
        send_byte(8'h12);
        send_byte(8'h34);
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        rst      = 1'b1;
        idle(1);
        rx_valid = 1'b0;
        rst      = 1'b0;
        check_all_zero("rst_dat");
        idle(2);
        check_val("rst_dat_txv", tx_valid, 1'b0);
        check_val("rst_dat_we", mem_write, 1'b0);

        // Reset while a read response waits for the transmitter.
        send_byte(8'h52);
        send_byte(8'h12);
        send_byte(8'h34);
        idle(2);
        check_val("rst_tx_pend", tx_valid, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_all_zero("rst_tx");
        idle(3);
        check_val("rst_tx_after", tx_valid, 1'b0);
        do_read(14'h1234, 2'b00, 0, 1'b0);

        // Random traffic over a small address pool so reads hit earlier writes.
        for (int n = 0; n < 40; n++) begin
            a = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) begin
                b = 8'($urandom);
                if (b == 8'h57 || b == 8'h52) b = 8'h00;
                send_byte(b);
                exp_err++;
                check_val("rnd_badop", err, 1'b1);
            end
            if ($urandom_range(0, 1) == 1)
                do_write(a, 2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3));
            else
                do_read(a, 2'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom_range(0, 3) == 0);
        end

        idle(2);
        check_val("err_count", err_seen, exp_err);
        check_val("wr_count", wr_seen, exp_wr);
        check_val("tx_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
